// File: rtl/as_sequencer_if.sv
// Sequencer <-> datapath/ROM bundle: run/ROM data/zero flag in, pc and decoded controls out.
interface as_sequencer_if #(
    parameter int unsigned pw = 8,
    parameter int unsigned n  = 8
);
    localparam int unsigned iw = 16;

    logic          run;
    logic [iw-1:0] instr;
    logic          z;
    logic [pw-1:0] pc;
    logic [1:0]    rd_addr;
    logic [1:0]    rs_addr;
    logic [n-1:0]  immediate;
    logic          reg_we;
    logic          add_a_sel;
    logic          add_b_sel;
    logic          acc_en;
    logic          acc_add;
    logic          in_en;
    logic          zflag;

    modport master (
        input  run, instr, z,
        output pc, rd_addr, rs_addr, immediate, reg_we, add_a_sel, add_b_sel,
               acc_en, acc_add, in_en, zflag
    );

    modport slave (
        output run, instr, z,
        input  pc, rd_addr, rs_addr, immediate, reg_we, add_a_sel, add_b_sel,
               acc_en, acc_add, in_en, zflag
    );
endinterface

// File: rtl/as_sequencer.sv
// Two-cycle FETCH/EXEC program sequencer and decoder feeding the ALU stage.
// Strobes are a pure function of state and the registered ROM word.
module as_sequencer #(
    parameter int unsigned pw = 8,
    parameter int unsigned n  = 8
) (
    input  logic          clk,
    input  logic          n_reset,
    as_sequencer_if.master bus
);
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] EXEC  = 1'b1;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_ADDI   = 3'b001;
    localparam logic [2:0] OP_MULADD = 3'b010;
    localparam logic [2:0] OP_IN     = 3'b011;
    localparam logic [2:0] OP_ACCLD  = 3'b100;
    localparam logic [2:0] OP_MAC    = 3'b101;
    localparam logic [2:0] OP_BRZ    = 3'b110;
    localparam logic [2:0] OP_WAITSW = 3'b111;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [pw-1:0] pc_q;
    logic [pw-1:0] pc_next;
    logic          zflag_q;
    logic          zflag_next;
    logic [2:0]    op;
    logic          reg_we;
    logic          add_a_sel;
    logic          add_b_sel;
    logic          acc_en;
    logic          acc_add;
    logic          in_en;
    logic          unused_bits;

    assign op          = bus.instr[15:13];
    assign unused_bits = bus.instr[8];

    // State, program counter and latched zero flag
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= FETCH;
            pc_q    <= '0;
            zflag_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_next;
            zflag_q <= zflag_next;
        end
    end

    // Next-state, pc/zflag update and decode strobes
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        zflag_next = zflag_q;
        reg_we     = 1'b0;
        add_a_sel  = 1'b0;
        add_b_sel  = 1'b0;
        acc_en     = 1'b0;
        acc_add    = 1'b0;
        in_en      = 1'b0;

        if (state == EXEC) begin
            state_next = FETCH;
            pc_next    = pc_q + pw'(1);
            case (op)
                OP_NOP: ;
                OP_ADDI: begin
                    reg_we     = 1'b1;
                    add_b_sel  = 1'b1;
                    zflag_next = bus.z;
                end
                OP_MULADD: begin
                    reg_we     = 1'b1;
                    zflag_next = bus.z;
                end
                OP_IN: begin
                    reg_we = 1'b1;
                    in_en  = 1'b1;
                end
                OP_ACCLD: begin
                    acc_en     = 1'b1;
                    zflag_next = bus.z;
                end
                OP_MAC: begin
                    acc_en     = 1'b1;
                    acc_add    = 1'b1;
                    zflag_next = bus.z;
                end
                OP_BRZ: begin
                    if (zflag_q) pc_next = pw'(bus.instr[7:0]);
                end
                OP_WAITSW: begin
                    add_a_sel = 1'b1;
                    add_b_sel = 1'b1;
                    // z high means switch bit 8 still low: stall in EXEC
                    if (bus.z) begin
                        state_next = EXEC;
                        pc_next    = pc_q;
                    end
                end
                default: ;
            endcase
        end else if (bus.run) begin
            state_next = EXEC;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.zflag     = zflag_q;
    assign bus.rd_addr   = bus.instr[12:11];
    assign bus.rs_addr   = bus.instr[10:9];
    assign bus.immediate = n'(bus.instr[7:0]);
    assign bus.reg_we    = reg_we;
    assign bus.add_a_sel = add_a_sel;
    assign bus.add_b_sel = add_b_sel;
    assign bus.acc_en    = acc_en;
    assign bus.acc_add   = acc_add;
    assign bus.in_en     = in_en;
endmodule

// File: tb/tb_as_sequencer.sv
// Bench for as_sequencer: directed scenarios plus a randomized program checked
// against an instruction-level model of pc/zflag and the opcode strobe table.
module tb_as_sequencer;
    localparam int unsigned pw = 8;
    localparam int unsigned n  = 8;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    as_sequencer_if #(.pw(pw), .n(n)) bus ();
    as_sequencer #(.pw(pw), .n(n)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));

    logic [15:0] rom [256];
    logic [15:0] rom_q;
    always @(posedge clk) rom_q <= rom[bus.pc];
    assign bus.instr = rom_q;

    logic [5:0] strb;
    assign strb = {bus.reg_we, bus.add_a_sel, bus.add_b_sel, bus.acc_en, bus.acc_add, bus.in_en};

    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 1'b0, imm};
    endfunction

    // {reg_we, add_a_sel, add_b_sel, acc_en, acc_add, in_en} per opcode
    function automatic logic [5:0] exp_strb(input logic [2:0] op);
        case (op)
            3'd1:    return 6'b101000;
            3'd2:    return 6'b100000;
            3'd3:    return 6'b100001;
            3'd4:    return 6'b000100;
            3'd5:    return 6'b000110;
            3'd7:    return 6'b011000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset;
        n_reset = 1'b0;
        bus.run = 1'b0;
        bus.z   = 1'b0;
        step;
        step;
        n_reset = 1'b1;
        bus.run = 1'b1;
    endtask

    task automatic test_reset;
        clear_rom;
        rom[0]  = enc(3'd1, 2'd1, 2'd0, 8'h05);
        n_reset = 1'b0;
        bus.run = 1'b1;
        bus.z   = 1'b1;
        step;
        step;
        total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h want=00", bus.pc); end
        total++; if (bus.zflag !== 1'b0) begin bad++; $display("FAIL reset_zflag got=%b want=0", bus.zflag); end
        total++; if (strb !== 6'b0) begin bad++; $display("FAIL reset_strobes got=%b want=000000", strb); end
    endtask

    task automatic test_addi_first;
        clear_rom;
        rom[0] = enc(3'd1, 2'd1, 2'd0, 8'h05);
        do_reset;
        step;
        total++; if (strb !== 6'b101000) begin bad++; $display("FAIL addi_strobes got=%b want=101000", strb); end
        total++; if (bus.immediate !== 8'h05) begin bad++; $display("FAIL addi_imm got=%h want=05", bus.immediate); end
        total++; if (bus.rd_addr !== 2'd1) begin bad++; $display("FAIL addi_rd got=%0d want=1", bus.rd_addr); end
        step;
        total++; if (bus.pc !== 8'h01) begin bad++; $display("FAIL addi_pc1 got=%h want=01", bus.pc); end
        total++; if (strb !== 6'b0) begin bad++; $display("FAIL fetch_strobes got=%b want=000000", strb); end
        step;
        step;
        total++; if (bus.pc !== 8'h02) begin bad++; $display("FAIL addi_pc2 got=%h want=02", bus.pc); end
    endtask

    task automatic test_brz;
        clear_rom;
        rom[0]    = enc(3'd1, 2'd0, 2'd0, 8'h01);
        rom[1]    = enc(3'd6, 2'd0, 2'd0, 8'h40);
        rom[8'h40] = enc(3'd1, 2'd0, 2'd0, 8'h01);
        rom[8'h41] = enc(3'd6, 2'd0, 2'd0, 8'h40);
        do_reset;
        step; bus.z = 1'b1;
        step;
        total++; if (bus.zflag !== 1'b1) begin bad++; $display("FAIL brz_zflag1 got=%b want=1", bus.zflag); end
        step; bus.z = 1'b0;
        total++; if (strb !== 6'b0) begin bad++; $display("FAIL brz_strobes got=%b want=000000", strb); end
        step;
        total++; if (bus.pc !== 8'h40) begin bad++; $display("FAIL brz_taken got=%h want=40", bus.pc); end
        step; bus.z = 1'b0;
        step;
        total++; if (bus.zflag !== 1'b0) begin bad++; $display("FAIL brz_zflag0 got=%b want=0", bus.zflag); end
        step; bus.z = 1'b1;
        step;
        total++; if (bus.pc !== 8'h42) begin bad++; $display("FAIL brz_not_taken got=%h want=42", bus.pc); end
    endtask

    task automatic test_in_muladd;
        clear_rom;
        rom[0] = enc(3'd1, 2'd0, 2'd0, 8'h00);
        rom[1] = enc(3'd3, 2'd2, 2'd0, 8'h00);
        rom[2] = enc(3'd2, 2'd1, 2'd3, 8'h81);
        do_reset;
        step; bus.z = 1'b1;
        step;
        step; bus.z = 1'b0;
        total++; if (strb !== 6'b100001) begin bad++; $display("FAIL in_strobes got=%b want=100001", strb); end
        total++; if (bus.rd_addr !== 2'd2) begin bad++; $display("FAIL in_rd got=%0d want=2", bus.rd_addr); end
        step;
        total++; if (bus.zflag !== 1'b1) begin bad++; $display("FAIL in_zflag_hold got=%b want=1", bus.zflag); end
        step; bus.z = 1'b0;
        total++; if (strb !== 6'b100000) begin bad++; $display("FAIL muladd_strobes got=%b want=100000", strb); end
        total++; if (bus.rs_addr !== 2'd3) begin bad++; $display("FAIL muladd_rs got=%0d want=3", bus.rs_addr); end
        step;
        total++; if (bus.zflag !== 1'b0) begin bad++; $display("FAIL muladd_zflag got=%b want=0", bus.zflag); end
    endtask

    task automatic test_waitsw;
        clear_rom;
        rom[0]     = enc(3'd1, 2'd0, 2'd0, 8'h00);
        rom[1]     = enc(3'd6, 2'd0, 2'd0, 8'h10);
        rom[8'h10] = enc(3'd7, 2'd0, 2'd0, 8'h00);
        do_reset;
        step; bus.z = 1'b1;
        step;
        step;
        step;
        for (int k = 0; k < 6; k++) begin
            step;
            bus.z = (k < 5) ? 1'b1 : 1'b0;
            total++; if (bus.pc !== 8'h10) begin bad++; $display("FAIL waitsw_pc%0d got=%h want=10", k, bus.pc); end
            total++; if (strb !== 6'b011000) begin bad++; $display("FAIL waitsw_strobes%0d got=%b want=011000", k, strb); end
        end
        step;
        total++; if (bus.pc !== 8'h11) begin bad++; $display("FAIL waitsw_exit got=%h want=11", bus.pc); end
        total++; if (strb !== 6'b0) begin bad++; $display("FAIL waitsw_fetch got=%b want=000000", strb); end
    endtask

    task automatic test_wrap_and_run;
        clear_rom;
        rom[0] = enc(3'd1, 2'd0, 2'd0, 8'h00);
        rom[1] = enc(3'd6, 2'd0, 2'd0, 8'hff);
        do_reset;
        step; bus.z = 1'b1;
        step;
        step;
        step;
        total++; if (bus.pc !== 8'hff) begin bad++; $display("FAIL wrap_pre got=%h want=ff", bus.pc); end
        step;
        step;
        total++; if (bus.pc !== 8'h00) begin bad++; $display("FAIL wrap got=%h want=00", bus.pc); end
        bus.run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            total++; if (bus.pc !== 8'h00 || strb !== 6'b0) begin bad++; $display("FAIL run0_hold%0d got pc=%h strb=%b want pc=00 strb=000000", k, bus.pc, strb); end
        end
        bus.run = 1'b1;
        step;
        bus.run = 1'b0;
        bus.z   = 1'b0;
        total++; if (strb !== 6'b101000) begin bad++; $display("FAIL run0_exec got=%b want=101000", strb); end
        step;
        step;
        step;
        total++; if (bus.pc !== 8'h01 || strb !== 6'b0) begin bad++; $display("FAIL run0_after got pc=%h strb=%b want pc=01 strb=000000", bus.pc, strb); end
        bus.run = 1'b1;
    endtask

    task automatic test_reset_mid_exec;
        clear_rom;
        rom[0] = enc(3'd1, 2'd0, 2'd0, 8'h00);
        rom[1] = enc(3'd5, 2'd0, 2'd1, 8'h33);
        do_reset;
        step; bus.z = 1'b1;
        step;
        step;
        total++; if (strb !== 6'b000110) begin bad++; $display("FAIL mac_strobes got=%b want=000110", strb); end
        #2 n_reset = 1'b0;
        #1;
        total++; if (bus.acc_en !== 1'b0 || bus.acc_add !== 1'b0) begin bad++; $display("FAIL rst_mid_strobes got=%b%b want=00", bus.acc_en, bus.acc_add); end
        total++; if (bus.pc !== 8'h00 || bus.zflag !== 1'b0) begin bad++; $display("FAIL rst_mid_state got pc=%h z=%b want pc=00 z=0", bus.pc, bus.zflag); end
        step;
        n_reset = 1'b1;
        bus.z   = 1'b0;
        step;
        total++; if (strb !== 6'b101000 || bus.pc !== 8'h00) begin bad++; $display("FAIL rst_release got strb=%b pc=%h want strb=101000 pc=00", strb, bus.pc); end
        step;
    endtask

    task automatic test_random;
        logic [7:0]  mpc;
        logic        mzf;
        logic [15:0] ins;
        logic [2:0]  op;
        logic        hold;
        int          stalls;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        do_reset;
        mpc  = 8'h00;
        mzf  = 1'b0;
        hold = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (hold || $urandom_range(7) == 0) begin
                bus.run = 1'b0;
                for (int h = 0; h < 2; h++) begin
                    step;
                    total++; if (bus.pc !== mpc || strb !== 6'b0) begin bad++; $display("FAIL rnd_hold k=%0d got pc=%h strb=%b want pc=%h strb=000000", k, bus.pc, strb, mpc); end
                end
                bus.run = 1'b1;
            end
            step;
            ins   = rom[mpc];
            op    = ins[15:13];
            bus.z = 1'($urandom_range(1));
            hold  = ($urandom_range(3) == 0);
            if (hold) bus.run = 1'b0;
            total++; if (strb !== exp_strb(op)) begin bad++; $display("FAIL rnd_strobes k=%0d op=%0d got=%b want=%b", k, op, strb, exp_strb(op)); end
            total++; if ({bus.rd_addr, bus.rs_addr, bus.immediate} !== {ins[12:9], ins[7:0]}) begin bad++; $display("FAIL rnd_fields k=%0d got=%h want=%h", k, {bus.rd_addr, bus.rs_addr, bus.immediate}, {ins[12:9], ins[7:0]}); end
            total++; if (bus.pc !== mpc) begin bad++; $display("FAIL rnd_exec_pc k=%0d got=%h want=%h", k, bus.pc, mpc); end
            stalls = 0;
            while (op == 3'd7 && bus.z == 1'b1) begin
                step;
                stalls++;
                bus.z = (stalls >= 6) ? 1'b0 : 1'($urandom_range(1));
                total++; if (bus.pc !== mpc || strb !== 6'b011000) begin bad++; $display("FAIL rnd_stall k=%0d got pc=%h strb=%b want pc=%h strb=011000", k, bus.pc, strb, mpc); end
            end
            if (op == 3'd6 && mzf) mpc = ins[7:0];
            else                   mpc = mpc + 8'd1;
            if (op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) mzf = bus.z;
            step;
            total++; if (bus.pc !== mpc || bus.zflag !== mzf) begin bad++; $display("FAIL rnd_retire k=%0d op=%0d got pc=%h z=%b want pc=%h z=%b", k, op, bus.pc, bus.zflag, mpc, mzf); end
        end
    endtask

    initial begin
        n_reset = 1'b0;
        bus.run = 1'b0;
        bus.z   = 1'b0;
        test_reset;
        test_addi_first;
        test_brz;
        test_in_muladd;
        test_waitsw;
        test_wrap_and_run;
        test_reset_mid_exec;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
